// File: rtl/aes_inv_cipher_pkg.sv
// Shared types, S-box tables, GF(2^8) and key-schedule helpers for
// the AES-128 inverse cipher. Optional key cache: AES_INV_KEY_CACHE_EN.
package aes_inv_cipher_pkg;

    localparam int P_BLOCK_W = 128;
    localparam int P_ROUNDS  = 10;
    localparam logic [3:0] LAST_RND = 4'(P_ROUNDS);

    typedef logic [7:0] u8_t;
    typedef logic [31:0] word_t;
    typedef logic [0:15][7:0] st_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEYEXP,
        S_ROUND,
        S_DONE
    } fsm_t;

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] ISBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic u8_t sbox(input u8_t b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic u8_t inv_sbox(input u8_t b);
        return ISBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic u8_t xtime(input u8_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic u8_t gmul(input u8_t a, input u8_t b);
        u8_t p;
        u8_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic u8_t rcon(input logic [3:0] i);
        unique case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic word_t rot_sub(input word_t w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic st_t fwd_key(input st_t k, input u8_t rc);
        word_t w0, w1, w2, w3;
        w0 = k[0:3];
        w1 = k[4:7];
        w2 = k[8:11];
        w3 = k[12:15];
        w0 = w0 ^ rot_sub(w3) ^ {rc, 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one schedule step: previous w3 first, since the g() term needs it.
    function automatic st_t inv_key(input st_t k, input u8_t rc);
        word_t n0, n1, n2, n3, w0, w1, w2, w3;
        n0 = k[0:3];
        n1 = k[4:7];
        n2 = k[8:11];
        n3 = k[12:15];
        w3 = n3 ^ n2;
        w2 = n2 ^ n1;
        w1 = n1 ^ n0;
        w0 = n0 ^ rot_sub(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Block handshake bundle for aes_inv_cipher: ciphertext/key in,
// plaintext out, each side with its own valid/ready pair.
interface aes_inv_cipher_if;
    import aes_inv_cipher_pkg::*;

    logic                 i_valid;
    logic                 o_ready;
    logic [0:P_BLOCK_W-1] i_cipher;
    logic [0:P_BLOCK_W-1] i_key;
    logic                 o_valid;
    logic                 i_ready;
    logic [0:P_BLOCK_W-1] o_plain;
    logic                 o_busy;

    modport slave (
        input  i_valid, i_cipher, i_key, i_ready,
        output o_ready, o_valid, o_plain, o_busy
    );

    modport master (
        output i_valid, i_cipher, i_key, i_ready,
        input  o_ready, o_valid, o_plain, o_busy
    );

endinterface

// File: rtl/aes_inv_cipher_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_cipher_round
    import aes_inv_cipher_pkg::*;
(
    input  st_t  state,
    input  st_t  rk,
    input  logic last,
    output st_t  result
);

    st_t ark;
    u8_t a0, a1, a2, a3;

    // Byte i sits at row i%4, column i/4; row r rotates right by r.
    always_comb begin
        ark = '0;
        for (int i = 0; i < 16; i++) begin
            ark[i] = inv_sbox(state[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)]) ^ rk[i];
        end
    end

    always_comb begin
        result = ark;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = ark[4 * c];
                a1 = ark[4 * c + 1];
                a2 = ark[4 * c + 2];
                a3 = ark[4 * c + 3];
                result[4 * c]     = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                result[4 * c + 1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                result[4 * c + 2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                result[4 * c + 3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Define AES_INV_KEY_CACHE_EN to reuse round key 10 for a repeated key.
module aes_inv_cipher
    import aes_inv_cipher_pkg::*;
(
    input  logic           i_clock,
    input  logic           i_reset_n,
    aes_inv_cipher_if.slave bus
);

    fsm_t       r_fsm, n_fsm;
    st_t        r_state, n_state;
    st_t        r_rk, n_rk;
    st_t        r_plain, n_plain;
    logic [3:0] r_cnt, n_cnt;
    logic       r_valid, n_valid;

    st_t  rk_fwd;
    st_t  rk_inv;
    st_t  rnd_out;
    st_t  crk10;
    logic accept;
    logic xfer;
    logic hit;
    logic kexp_exit;

    assign accept    = bus.i_valid && (r_fsm == S_IDLE);
    assign xfer      = r_valid && bus.i_ready;
    assign kexp_exit = (r_fsm == S_KEYEXP) && (r_cnt == LAST_RND);
    assign rk_fwd    = fwd_key(r_rk, rcon(r_cnt));
    assign rk_inv    = inv_key(r_rk, rcon(r_cnt + 4'd1));

    aes_inv_cipher_round u_round (
        .state  (r_state),
        .rk     (rk_inv),
        .last   (r_cnt == 4'd0),
        .result (rnd_out)
    );

`ifdef AES_INV_KEY_CACHE_EN
    st_t  r_key;
    st_t  r_ckey;
    st_t  r_crk;
    logic r_cvalid;

    // The original key is kept until expansion finishes, then paired with rk10.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_key    <= '0;
            r_ckey   <= '0;
            r_crk    <= '0;
            r_cvalid <= 1'b0;
        end else begin
            if (accept) r_key <= bus.i_key;
            if (kexp_exit) begin
                r_ckey   <= r_key;
                r_crk    <= rk_fwd;
                r_cvalid <= 1'b1;
            end
        end
    end

    assign hit   = r_cvalid && (r_ckey == bus.i_key);
    assign crk10 = r_crk;
`else
    assign hit   = 1'b0;
    assign crk10 = '0;
`endif

    always_comb begin
        n_fsm   = r_fsm;
        n_state = r_state;
        n_rk    = r_rk;
        n_cnt   = r_cnt;
        n_plain = r_plain;
        n_valid = r_valid;
        unique case (r_fsm)
            S_IDLE: begin
                if (accept && hit) begin
                    n_state = bus.i_cipher ^ crk10;
                    n_rk    = crk10;
                    n_cnt   = LAST_RND - 4'd1;
                    n_fsm   = S_ROUND;
                end else if (accept) begin
                    n_state = bus.i_cipher;
                    n_rk    = bus.i_key;
                    n_cnt   = 4'd1;
                    n_fsm   = S_KEYEXP;
                end
            end
            S_KEYEXP: begin
                n_rk = rk_fwd;
                if (kexp_exit) begin
                    n_state = r_state ^ rk_fwd;
                    n_cnt   = LAST_RND - 4'd1;
                    n_fsm   = S_ROUND;
                end else begin
                    n_cnt = r_cnt + 4'd1;
                end
            end
            S_ROUND: begin
                n_rk    = rk_inv;
                n_state = rnd_out;
                if (r_cnt == 4'd0) begin
                    n_plain = rnd_out;
                    n_valid = 1'b1;
                    n_fsm   = S_DONE;
                end else begin
                    n_cnt = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                if (xfer) begin
                    n_valid = 1'b0;
                    n_fsm   = S_IDLE;
                end
            end
            default: n_fsm = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_rk    <= '0;
            r_cnt   <= '0;
            r_plain <= '0;
            r_valid <= 1'b0;
        end else begin
            r_fsm   <= n_fsm;
            r_state <= n_state;
            r_rk    <= n_rk;
            r_cnt   <= n_cnt;
            r_plain <= n_plain;
            r_valid <= n_valid;
        end
    end

    assign bus.o_ready = (r_fsm == S_IDLE);
    assign bus.o_valid = r_valid;
    assign bus.o_plain = r_plain;
    assign bus.o_busy  = (r_fsm == S_KEYEXP) || (r_fsm == S_ROUND);

endmodule
